multi_button_debouncer: RTL
===========================

MULTI_BUTTON_DEBOUNCER -- requirements
Module: multi_button_debouncer

Interface
REQ-001 Parameter N_BUTTONS, default 4, number of independent button channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable clk cycles required to accept a level change (>=2).
REQ-003 Parameter ACTIVE_LOW, default 1, 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".
REQ-004 Parameter REPEAT_EN, default 0, 1 enables auto-repeat press pulses while a button is held.
REQ-005 Parameter REPEAT_DELAY, default 25000000, held cycles from accepted press to first repeat pulse (>=1).
REQ-006 Parameter REPEAT_RATE, default 10000000, cycles between subsequent repeat pulses (>=1).
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 button_in  input  N_BUTTONS  raw asynchronous button levels, bit i = channel i.
REQ-010 button_level  output  N_BUTTONS  debounced level, 1 = pressed, polarity-normalised.
REQ-011 button_press  output  N_BUTTONS  one-cycle pulse per accepted press or repeat event.
REQ-012 button_release  output  N_BUTTONS  one-cycle pulse per accepted release.
REQ-013 single_press  output  1  one-cycle pulse when exactly one bit of button_press is set.
REQ-014 multi_press  output  1  one-cycle pulse when two or more bits of button_press are set in the same cycle.

Function
REQ-015 Each channel shall pass button_in through a 2-flop synchroniser, then XOR with ACTIVE_LOW to form the normalised signal s[i].
REQ-016 Each channel shall have an independent counter of width $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_RATE)+1).
REQ-017 When s[i] equals button_level[i], the debounce counter shall be cleared to 0.
REQ-018 When s[i] differs from button_level[i], the counter shall increment; on the cycle it would reach DEBOUNCE_CYCLES, button_level[i] shall toggle and the counter shall clear.
REQ-019 Any glitch in s[i] shorter than DEBOUNCE_CYCLES cycles shall clear the counter and produce no output change.
REQ-020 Latency: a clean input transition held steady shall update button_level exactly 2+DEBOUNCE_CYCLES rising edges after the first edge sampling the new value.
REQ-021 button_press[i] shall assert in the same cycle button_level[i] rises 0->1, for exactly one cycle.
REQ-022 button_release[i] shall assert in the same cycle button_level[i] falls 1->0, for exactly one cycle.
REQ-023 Per-channel repeat FSM states: IDLE, HOLD_DELAY, HOLD_REPEAT.
REQ-024 IDLE->HOLD_DELAY on accepted press, only when REPEAT_EN=1.
REQ-025 HOLD_DELAY->HOLD_REPEAT after REPEAT_DELAY held cycles, emitting one button_press pulse.
REQ-026 In HOLD_REPEAT, a button_press pulse shall be emitted every REPEAT_RATE cycles.
REQ-027 Any state->IDLE on accepted release, with the repeat counter cleared in the same cycle; no repeat pulse in the release cycle.
REQ-028 With REPEAT_EN=0, the FSM shall remain IDLE and exactly one button_press shall occur per accepted press.
REQ-029 Channels shall be fully independent; a simultaneous press on several channels shall pulse each bit and assert multi_press, not single_press.
REQ-030 single_press and multi_press shall be combinational decodes of the registered button_press, mutually exclusive, both 0 when button_press is 0.

Reset
REQ-031 While reset=1, button_level, button_press, button_release, single_press and multi_press shall be 0, and all counters shall be 0.
REQ-032 While reset=1, all FSMs shall be IDLE and synchroniser flops shall hold the released level (ACTIVE_LOW ? 1 : 0).
REQ-033 A button already held when reset deasserts shall be accepted as a new press after 2+DEBOUNCE_CYCLES cycles.
REQ-034 Reset asserted mid-debounce or mid-repeat shall abort the operation with no pulse emitted.

Verification (N_BUTTONS=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=20, REPEAT_RATE=8 unless noted)
REQ-035 button_in[0] 1->0 held 20 cycles -> button_level[0]=1 and a single button_press[0] pulse 6 cycles after the change; button_release[0] pulse 6 cycles after returning to 1.
REQ-036 button_in[1] toggles low for 3 cycles, high for 1, repeated 10 times -> button_level, button_press and button_release stay 0.
REQ-037 button_in[2] and button_in[3] fall on the same cycle -> button_press=4'b1100 for one cycle, multi_press=1, single_press=0.
REQ-038 REPEAT_EN=1, button_in[0] held low 60 cycles -> press pulses at +6, +26, +34, +42, +50, +58 cycles; release stops repeats.
REQ-039 reset pulsed during 2nd debounce cycle of a press -> no pulse; input still held -> press pulse 6 cycles after reset deasserts.
REQ-040 ACTIVE_LOW=0, button_in[0] 0->1 held -> button_level[0]=1 with a single press pulse at +6 cycles.

Source files
------------

// File: rtl/multi_button_debouncer.sv
// rtl/multi_button_debouncer.sv - multi-channel button debouncer with press/release pulses and auto-repeat
module multi_button_debouncer #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] button_in,
    output logic [N_BUTTONS-1:0] button_level,
    output logic [N_BUTTONS-1:0] button_press,
    output logic [N_BUTTONS-1:0] button_release,
    output logic                 single_press,
    output logic                 multi_press
);
    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

    // Raw level of a released button; also the XOR mask that makes 1 mean pressed.
    localparam logic [N_BUTTONS-1:0] REL_RAW = (ACTIVE_LOW != 0) ? {N_BUTTONS{1'b1}} : {N_BUTTONS{1'b0}};
    localparam logic                 REP_ON  = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } rpt_state_e;

    logic [N_BUTTONS-1:0] sync1_q;
    logic [N_BUTTONS-1:0] sync2_q;
    logic [N_BUTTONS-1:0] norm;
    logic [N_BUTTONS-1:0] press_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= REL_RAW;
            sync2_q <= REL_RAW;
        end else begin
            sync1_q <= button_in;
            sync2_q <= sync1_q;
        end
    end

    assign norm = sync2_q ^ REL_RAW;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        logic [CW-1:0] db_cnt_q;
        logic [CW-1:0] db_cnt_d;
        logic [CW-1:0] rp_cnt_q;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        rpt_state_e    state_q;
        logic          accept;
        logic          accept_press;
        logic          accept_release;
        logic          rpt_due;
        logic          rpt_fire;

        assign accept         = (norm[i] != level_q) && (db_cnt_q == DB_LAST);
        assign accept_press   = accept && norm[i];
        assign accept_release = accept && !norm[i];
        assign db_cnt_d       = ((norm[i] == level_q) || accept) ? '0 : db_cnt_q + 1'b1;

        // A release accepted in the same cycle a repeat falls due wins: no pulse.
        assign rpt_due  = ((state_q == HOLD_DELAY)  && (rp_cnt_q == RD_LAST)) ||
                          ((state_q == HOLD_REPEAT) && (rp_cnt_q == RR_LAST));
        assign rpt_fire = rpt_due && !accept_release;

        always_ff @(posedge clk) begin
            if (reset) begin
                db_cnt_q  <= '0;
                rp_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                state_q   <= IDLE;
            end else begin
                db_cnt_q  <= db_cnt_d;
                press_q   <= accept_press || rpt_fire;
                release_q <= accept_release;
                if (accept) begin
                    level_q <= norm[i];
                end
                case (state_q)
                    IDLE: begin
                        rp_cnt_q <= '0;
                        if (accept_press && REP_ON) begin
                            state_q <= HOLD_DELAY;
                        end
                    end
                    HOLD_DELAY, HOLD_REPEAT: begin
                        if (accept_release) begin
                            state_q  <= IDLE;
                            rp_cnt_q <= '0;
                        end else if (rpt_due) begin
                            state_q  <= HOLD_REPEAT;
                            rp_cnt_q <= '0;
                        end else begin
                            rp_cnt_q <= rp_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        rp_cnt_q <= '0;
                    end
                endcase
            end
        end

        assign button_level[i]   = level_q;
        assign press_vec[i]      = press_q;
        assign button_release[i] = release_q;
    end

    assign button_press = press_vec;
    assign multi_press  = |(press_vec & (press_vec - N_BUTTONS'(1)));
    assign single_press = (|press_vec) && !multi_press;

endmodule
